// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage and its alignment helper.
//   MEM_OP_*  : mem_op field values from execute
//   MEM_SEL_* : access size / signedness encodings
//   state_t   : memory-stage transaction state
package mem_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  localparam logic [2:0] MEM_SEL_B  = 3'b000;
  localparam logic [2:0] MEM_SEL_H  = 3'b001;
  localparam logic [2:0] MEM_SEL_W  = 3'b010;
  localparam logic [2:0] MEM_SEL_BU = 3'b100;
  localparam logic [2:0] MEM_SEL_HU = 3'b101;

  typedef enum logic {IDLE, BUS} state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the memory stage.
// Store side (incoming instruction):
//   mem_sel, addr_off, store_data -> wdata (lane-replicated), be, misalign
// Load side (outstanding transaction):
//   load_sel, load_off, rdata -> load_data (lane-selected, sign/zero extended)
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  mem_sel,
  input  logic [1:0]  addr_off,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign,
  input  logic [2:0]  load_sel,
  input  logic [1:0]  load_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Store lanes are replicated across the word so the byte enables alone
  // pick the target lane. Illegal sizes get no enables and flag a fault.
  always_comb begin
    wdata    = store_data;
    be       = 4'b0000;
    misalign = 1'b0;
    case (mem_sel)
      MEM_SEL_B, MEM_SEL_BU: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_off;
      end
      MEM_SEL_H, MEM_SEL_HU: begin
        wdata    = {2{store_data[15:0]}};
        be       = 4'b0011 << addr_off;
        misalign = addr_off[0];
      end
      MEM_SEL_W: begin
        be       = 4'b1111;
        misalign = (addr_off != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by size. Word
  // accesses are always aligned here, so the shift is zero for them.
  always_comb begin
    shifted   = rdata >> {load_off, 3'b000};
    load_data = 32'h0;
    case (load_sel)
      MEM_SEL_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_SEL_BU: load_data = {24'h0, shifted[7:0]};
      MEM_SEL_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_SEL_HU: load_data = {16'h0, shifted[15:0]};
      MEM_SEL_W:  load_data = shifted;
      default:    load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: one outstanding request/ack data-memory access,
// load alignment/extension, and a valid/ready registered result.
//   clk, rst                : clock, async active-high reset
//   in_valid/in_ready/flush : upstream handshake and kill
//   alu_result .. pc_adder_result : instruction fields from execute
//   dmem_*                  : data-memory bus (request held until ack)
//   out_valid/out_ready     : downstream handshake
//   out_*                   : registered result fields
//   misalign, bus_err       : fault flags travelling with the result
module memory_stage
  import mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  mem_sel,
  input  logic [1:0]  wb_sel,
  input  logic [4:0]  rd,
  input  logic        reg_we,
  input  logic [31:0] pc_adder_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_load_data,
  output logic [31:0] out_pc_adder_result,
  output logic [1:0]  out_wb_sel,
  output logic [4:0]  out_rd,
  output logic        out_reg_we,
  output logic        misalign,
  output logic        bus_err
);

  state_t      state, state_next;
  logic [15:0] count;
  logic        p_is_load;
  logic        p_flushed;
  logic [2:0]  p_sel;
  logic [1:0]  p_off;
  logic        accept, is_mem, ack_done, timeout_hit;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;
  logic        st_misalign;

  load_store_align u_align (
    .mem_sel   (mem_sel),
    .addr_off  (alu_result[1:0]),
    .store_data(rs2_data),
    .wdata     (st_wdata),
    .be        (st_be),
    .misalign  (st_misalign),
    .load_sel  (p_sel),
    .load_off  (p_off),
    .rdata     (dmem_rdata),
    .load_data (ld_data)
  );

  assign in_ready    = (state == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready && !flush;
  assign is_mem      = (mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE);
  assign ack_done    = (state == BUS) && dmem_ack;
  // Ack on the final cycle takes priority over the timeout.
  assign timeout_hit = (state == BUS) && !dmem_ack && (count == 16'(BUS_TIMEOUT - 1));

  // Only aligned loads/stores touch the bus; everything else resolves in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mem && !st_misalign) state_next = BUS;
      BUS:  if (ack_done || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Result and bus registers. Pass-through fields are captured at
  // acceptance; out_valid stays low through BUS so they may change freely
  // then. A flush seen in any BUS cycle suppresses the eventual result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count               <= '0;
      p_is_load           <= 1'b0;
      p_flushed           <= 1'b0;
      p_sel               <= '0;
      p_off               <= '0;
      dmem_req            <= 1'b0;
      dmem_we             <= 1'b0;
      dmem_addr           <= '0;
      dmem_wdata          <= '0;
      dmem_be             <= '0;
      out_valid           <= 1'b0;
      out_alu_result      <= '0;
      out_load_data       <= '0;
      out_pc_adder_result <= '0;
      out_wb_sel          <= '0;
      out_rd              <= '0;
      out_reg_we          <= 1'b0;
      misalign            <= 1'b0;
      bus_err             <= 1'b0;
    end else if (state == IDLE) begin
      if (out_ready || flush) out_valid <= 1'b0;
      if (accept) begin
        out_alu_result      <= alu_result;
        out_pc_adder_result <= pc_adder_result;
        out_wb_sel          <= wb_sel;
        out_rd              <= rd;
        out_load_data       <= '0;
        bus_err             <= 1'b0;
        if (!is_mem) begin
          out_valid  <= 1'b1;
          out_reg_we <= reg_we;
          misalign   <= 1'b0;
        end else if (st_misalign) begin
          out_valid  <= 1'b1;
          out_reg_we <= 1'b0;
          misalign   <= 1'b1;
        end else begin
          out_reg_we <= reg_we;
          misalign   <= 1'b0;
          dmem_req   <= 1'b1;
          dmem_we    <= (mem_op == MEM_OP_STORE);
          dmem_addr  <= {alu_result[31:2], 2'b00};
          dmem_wdata <= st_wdata;
          dmem_be    <= st_be;
          count      <= '0;
          p_is_load  <= (mem_op == MEM_OP_LOAD);
          p_flushed  <= 1'b0;
          p_sel      <= mem_sel;
          p_off      <= alu_result[1:0];
        end
      end
    end else begin
      if (flush) p_flushed <= 1'b1;
      if (ack_done) begin
        dmem_req <= 1'b0;
        count    <= '0;
        if (p_is_load) out_load_data <= ld_data;
        out_valid <= !(p_flushed || flush);
      end else if (timeout_hit) begin
        dmem_req   <= 1'b0;
        count      <= '0;
        bus_err    <= 1'b1;
        out_reg_we <= 1'b0;
        out_valid  <= !(p_flushed || flush);
      end else begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute stage. It consumes the ALU result as the address, rs2 data as store data, and the mem_op/mem_sel/wb_sel/rd/reg_we control fields. It runs a single outstanding request/ack transaction on the data-memory bus, aligns and extends load data, and presents a registered, valid/ready-handshaked result to writeback.

Parameters:
BUS_TIMEOUT, 255, cycles to wait in BUS for dmem_ack before the access is aborted with bus_err (range 1..65535).

Ports:
clk  in  1  clock; sole clock domain
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  execute presents an instruction
in_ready  out  1  stage can accept this cycle
flush  in  1  kill the instruction being accepted, and any buffered or unissued result
alu_result  in  32  effective address / ALU value
rs2_data  in  32  store data
mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
mem_sel  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
wb_sel  in  2  writeback source, passed through
rd  in  5  destination register, passed through
reg_we  in  1  register write enable, passed through
pc_adder_result  in  32  link value, passed through
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  32  word address, {alu_result[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  bus completion, one cycle
dmem_rdata  in  32  read word, valid with dmem_ack
out_valid  out  1  result available to writeback
out_ready  in  1  writeback accepts
out_alu_result  out  32  registered alu_result
out_load_data  out  32  aligned, extended load data (0 for non-loads)
out_pc_adder_result  out  32  registered link value
out_wb_sel  out  2  registered wb_sel
out_rd  out  5  registered rd
out_reg_we  out  1  registered reg_we, forced 0 on any fault
misalign  out  1  fault: misaligned access or illegal mem_sel
bus_err  out  1  fault: timeout

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. On reset, state = IDLE, the timeout counter = 0, and every output register is 0 (dmem_req, out_valid, all out_* fields, misalign, bus_err, dmem_*). Reset asserted mid-transaction abandons the transaction; no ack is awaited afterwards.
- States:
  - IDLE: no transaction outstanding.
  - BUS: dmem_req is held high until ack or timeout.
- Acceptance: in_ready = (state==IDLE) && (!out_valid || out_ready). An instruction is accepted when in_valid && in_ready && !flush.
- mem_op none/reserved: on the accepting edge, the out_* fields are loaded and out_valid rises. Latency is 1 cycle.
- Fault check on acceptance:
  - misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0, or illegal mem_sel.
  - On a fault: no bus access; the result is registered with misalign=1 and out_reg_we=0; latency 1.
- Aligned load/store: on acceptance, go to BUS. dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are registered and held stable until ack.
  - Byte store: wdata = {4{rs2[7:0]}}, be = 0001 << addr[1:0].
  - Half store: wdata = {2{rs2[15:0]}}, be = 0011 << addr[1:0].
  - Word store: wdata = rs2, be = 1111.
  - Loads: be per size, dmem_we = 0.
- BUS exit on ack: on the dmem_ack edge, dmem_req drops. For a load, out_load_data = lane from addr[1:0], sign-extended for B/H and zero-extended for BU/HU. out_valid rises and the state returns to IDLE.
  - Minimum latency is 2 cycles (ack in the first BUS cycle).
  - dmem_ack outside BUS is ignored.
- Timeout: the counter increments each BUS cycle without ack. When it reaches BUS_TIMEOUT, dmem_req drops and the result is registered with bus_err=1 and out_reg_we=0; state returns to IDLE. Ack and timeout on the same cycle: ack wins.
- Output hold: while out_valid && !out_ready, all out_* fields and the fault flags are stable. When out_ready is sampled high, out_valid clears unless a new result is loaded on the same edge (back-to-back, no bubble).
- Flush:
  - In IDLE, flush blocks acceptance and clears out_valid.
  - In BUS, the transaction completes normally (a store still commits), but the result is discarded: out_valid stays 0.
- Fault flags clear whenever a new non-faulting result is loaded.

Decomposition:
- Shared package mem_pkg holds:
  - MEM_OP_NONE/LOAD/STORE encodings;
  - MEM_SEL_B/H/W/BU/HU encodings;
  - the state enum {IDLE, BUS}.
- One combinational sub-module, load_store_align: store lane replication and byte enables, load lane select and extension, and the misalign decode. The FSM, timeout counter and output register stay in memory_stage.

Test Plan:
- Word load, addr 0x100, ack on the 3rd BUS cycle, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111, out_load_data 0xDEADBEEF, out_valid 3 cycles after acceptance.
- Signed byte load (B), addr 0x103, rdata 0x80112233 -> be 1000, out_load_data 0xFFFFFF80. The same access as BU -> 0x00000080.
- Half store, addr 0x202, rs2 0x1234ABCD -> dmem_we 1, wdata 0xABCDABCD, be 1100, dmem_addr 0x200, out_reg_we as input.
- Word load at 0x101 -> no dmem_req, out_valid next cycle, misalign=1, out_reg_we=0. Then mem_op none with out_ready held low 3 cycles -> in_ready 0 and outputs stable until out_ready.
- BUS_TIMEOUT=4, no ack -> dmem_req high exactly 4 cycles, then bus_err=1, out_reg_we=0, in_ready returns 1.
- Flush during BUS on a store, then ack -> write completes, out_valid never asserts. Reset asserted mid-BUS -> dmem_req and out_valid 0 immediately, asynchronously.
